// File: rtl/truth_table_sweeper.sv
// Stimulus/capture controller for a 4-input, 2-output combinational block.
// Walks all 16 minterms, samples E/F after a settle delay and grades the tables.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] exp_e,
  input  logic [15:0] exp_f,
  input  logic        E,
  input  logic        F,
  output logic        W,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        busy,
  output logic        done,
  output logic [15:0] e_table,
  output logic [15:0] f_table,
  output logic        pass,
  output logic [3:0]  err_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] e_tab_q, e_tab_d;
  logic [15:0] f_tab_q, f_tab_d;
  logic        pass_q, pass_d;
  logic [3:0]  err_q, err_d;

  logic [15:0] e_full, f_full, miss;
  logic [3:0]  first_miss;

  // Grading must include the minterm being sampled this cycle, so merge it in
  // before comparing rather than waiting a cycle for the table register.
  always_comb begin
    e_full        = e_tab_q;
    e_full[idx_q] = E;
    f_full        = f_tab_q;
    f_full[idx_q] = F;
    miss          = (e_full ^ exp_e) | (f_full ^ exp_f);
    first_miss    = '0;
    for (int i = 15; i >= 0; i--) begin
      if (miss[i]) first_miss = 4'(i);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    e_tab_d = e_tab_q;
    f_tab_d = f_tab_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          e_tab_d = '0;
          f_tab_d = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        e_tab_d = e_full;
        f_tab_d = f_full;
        if (idx_q == 4'hF) begin
          pass_d  = (miss == 16'h0000);
          err_d   = first_miss;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      e_tab_q <= '0;
      f_tab_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      e_tab_q <= e_tab_d;
      f_tab_q <= f_tab_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // The drive follows idx directly, so the last minterm stays up after a sweep.
  assign {W, X, Y, Z} = idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign e_table      = e_tab_q;
  assign f_table      = f_tab_q;
  assign pass         = pass_q;
  assign err_idx      = err_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively exercises a 4-input, 2-output combinational block (W, X, Y, Z -> E, F). It drives all 16 input minterms in ascending order, waits a programmable settle time per minterm, and captures E and F into two 16-bit truth-table registers. At the end of the sweep it compares the captured tables against expected tables and reports pass/fail and the first failing minterm. It sits beside the combinational block as its stimulus/capture controller, replacing a hand-written exhaustive stimulus list.

## Interface
- SETTLE, default 1: cycles each minterm is held before sampling; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  active-low synchronous reset; one clock, synchronous reset.
- start  input  1  sweep request; sampled only in IDLE.
- exp_e  input  16  expected E table; bit i = E at minterm i.
- exp_f  input  16  expected F table; bit i = F at minterm i.
- E  input  1  combinational block output E.
- F  input  1  combinational block output F.
- W, X, Y, Z  output  1 each  minterm drive; minterm index i = {W,X,Y,Z}, W is the MSB.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  output  1  one-cycle pulse at sweep completion.
- e_table  output  16  captured E table.
- f_table  output  16  captured F table.
- pass  output  1  1 when both captured tables equal the expected tables; valid from done.
- err_idx  output  4  lowest minterm where E or F mismatched; 0 when pass=1.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: with start=1, set idx=0, cnt=0, clear e_table, f_table, pass and err_idx, and go to SETTLE. With start=0, stay.
- SETTLE: drive {W,X,Y,Z}=idx. Increment cnt. When cnt==SETTLE-1, go to SAMPLE.
- SAMPLE: latch e_table[idx]<=E and f_table[idx]<=F. Then:
  - idx==15: go to DONE.
  - otherwise: idx<=idx+1, cnt<=0, go to SETTLE.
- DONE: done=1 for this cycle only. Return to IDLE.
- pass and err_idx are registered on the SAMPLE->DONE transition, using the fully captured tables including minterm 15.
- err_idx is the lowest i with (e_table^exp_e)|(f_table^exp_f) set.
- exp_e and exp_f must be stable from start until done.
- W, X, Y, Z hold the last minterm (all 1) in DONE and IDLE until the next sweep. After reset they are 0.
- start while busy is ignored. There is no queueing.
- start held high in the DONE cycle does not retrigger. It is accepted on the next IDLE cycle.
- e_table, f_table, pass and err_idx hold their values from done until the next accepted start.

## Timing
- Reset values (rst_n=0 at a clock edge): state=IDLE; idx=0, cnt=0; W=X=Y=Z=0; busy=0, done=0, pass=0; err_idx=0; e_table=f_table=16'h0000.
- Reset mid-sweep aborts immediately: no done pulse, tables cleared.
- Each minterm occupies SETTLE+1 cycles (SETTLE cycles in SETTLE, 1 in SAMPLE). E and F are sampled after the minterm has been driven for SETTLE full cycles.
- Let start be sampled high in IDLE at edge T0. Then done is high in cycle 16*(SETTLE+1)+1 after T0. With SETTLE=1, done is high in cycle 33.
- busy=1 from T0 through the DONE cycle. busy=0 in the following IDLE cycle.
- Minimum spacing between the starts of consecutive sweeps: 16*(SETTLE+1)+2 cycles.
- idx wraps only via DONE. It never increments past 15.

## Test plan
- Reset, then start with SETTLE=1 and a model E=W^X, F=Y&Z. Expected: done in cycle 33, e_table=16'h0FF0, f_table=16'h8888. With exp_e=16'h0FF0 and exp_f=16'h8888: pass=1, err_idx=0.
- Same model with exp_f=16'h8880 -> pass=0, err_idx=3.
- Same model with exp_e bits 9 and 14 flipped -> pass=0, err_idx=9.
- SETTLE=3, model E=1, F=0 -> done in cycle 65, e_table=16'hFFFF, f_table=16'h0000.
- Check the drive sequence: {W,X,Y,Z} steps 0..15, each value held exactly SETTLE+1 cycles.
- Pulse start at cycles 5 and 20 after an accepted start -> exactly one done pulse. Then assert rst_n=0 at cycle 10 of a second sweep -> no done; all outputs at their reset values on the next cycle.
